// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one word-addressed memory between
// port A (CPU) and port B (loader/DMA); one access per SERVE cycle, registered ack.
module mem_arbiter #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 1024
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic          a_err,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic          b_err,
    output logic [DW-1:0] b_rdata,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    // One extra bit so DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

    state_t state, state_nxt;
    grant_t last_grant, last_grant_nxt;

    logic a_in_range, b_in_range;
    logic serve_a, serve_b;

    assign a_in_range = {1'b0, a_addr} < DEPTH_X;
    assign b_in_range = {1'b0, b_addr} < DEPTH_X;
    assign serve_a    = (state == SERVE_A);
    assign serve_b    = (state == SERVE_B);

    // State and round-robin pointer; reset leaves B as last grant so A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GRANT_B;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Arbitration and memory drive; memory port is quiet outside SERVE.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;

        case (state)
            IDLE: begin
                if (a_req && b_req) begin
                    state_nxt = (last_grant == GRANT_B) ? SERVE_A : SERVE_B;
                end else if (a_req) begin
                    state_nxt = SERVE_A;
                end else if (b_req) begin
                    state_nxt = SERVE_B;
                end
            end
            SERVE_A: begin
                mem_we         = a_we & a_in_range;
                mem_addr       = a_addr;
                mem_wdata      = a_wdata;
                last_grant_nxt = GRANT_A;
                state_nxt      = IDLE;
            end
            SERVE_B: begin
                mem_we         = b_we & b_in_range;
                mem_addr       = b_addr;
                mem_wdata      = b_wdata;
                last_grant_nxt = GRANT_B;
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Completion outputs: ack/err pulse for one cycle, rdata held until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_ack   <= 1'b0;
            a_err   <= 1'b0;
            a_rdata <= '0;
            b_ack   <= 1'b0;
            b_err   <= 1'b0;
            b_rdata <= '0;
        end else begin
            a_ack <= serve_a;
            a_err <= serve_a & ~a_in_range;
            b_ack <= serve_b;
            b_err <= serve_b & ~b_in_range;
            if (serve_a) begin
                a_rdata <= (a_in_range && !a_we) ? mem_rdata : '0;
            end
            if (serve_b) begin
                b_rdata <= (b_in_range && !b_we) ? mem_rdata : '0;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single word-addressed `MainMemory` between two requesters: port A (CPU data path) and port B (debug loader / DMA). It serialises accesses, drives the memory's write-enable, address and write-data inputs, and returns registered read data with a one-cycle acknowledge pulse. Out-of-range addresses are rejected with an error flag and never reach the memory.

## Interface

- `AW`, 32: address width of both request ports and the memory address port.
- `DW`, 32: data width.
- `DEPTH`, 1024: number of memory words; valid word addresses are 0..DEPTH-1.

Ports:

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous reset, active-low.
- `a_req` input 1: port A request; held with `a_we`/`a_addr`/`a_wdata` stable until `a_ack`.
- `a_we` input 1: port A write (1) or read (0).
- `a_addr` input AW: port A word address.
- `a_wdata` input DW: port A write data.
- `a_ack` output 1: one-cycle completion pulse for port A.
- `a_err` output 1: valid with `a_ack`; address out of range.
- `a_rdata` output DW: port A read data, registered and held until the next port A completion.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`, `b_err`, `b_rdata`: identical to the port A signals, for port B.
- `mem_we` output 1: memory write enable.
- `mem_addr` output AW: memory address.
- `mem_wdata` output DW: memory write data.
- `mem_rdata` input DW: memory combinational read data.

## Operation

- **FSM states:** IDLE, SERVE_A, SERVE_B.
- **IDLE:**
  - Request present on A only: go to SERVE_A. Request present on B only: go to SERVE_B.
  - Requests on both: grant the port that is not `last_grant`.
  - No request: stay in IDLE.
- **SERVE_x (lasts exactly one cycle):**
  - `mem_addr`/`mem_wdata` come combinationally from port x.
  - `mem_we = x_we & in_range`, where `in_range = (x_addr < DEPTH)` is an unsigned compare.
  - At the end of the cycle:
    - `x_rdata` is set to `(in_range & ~x_we) ? mem_rdata : 0`.
    - `x_err` is set to `~in_range`.
    - `x_ack` is set to 1 and `last_grant` is set to x.
    - The FSM returns to IDLE.
- **Write data capture:** a write leaves `x_rdata` at 0. The memory captures the data at the edge that ends SERVE_x.
- **Ack cycle:** `x_ack` and `x_err` are registered and are high only in the cycle after SERVE_x. That cycle is IDLE.
  - If `x_req` is still high in the ack cycle, the FSM treats it as a new transaction and arbitrates it immediately.
  - A requester with nothing further to issue must drop `req` in its ack cycle.
- **Idle memory outputs:** when not in SERVE, `mem_we = 0`, `mem_addr = 0` and `mem_wdata = 0`.
- **Fairness:** under continuous requests from both ports, grants strictly alternate. A waiting port is granted within 2 arbitration slots (at most 4 cycles).
- **Request withdrawal:** a requester must not drop `req` before its ack arrives. If it does while the FSM is in IDLE, no grant is issued. A drop during SERVE does not abort the access.

## Timing

- **Reset values:** `a_ack`, `b_ack`, `a_err` and `b_err` are 0. `a_rdata` and `b_rdata` are 0. State is IDLE. `last_grant` is B, so A wins the first tie. `mem_we`, `mem_addr` and `mem_wdata` are 0.
- **Latency:** `req` is first sampled high at edge N. SERVE occupies cycle N..N+1. Ack and rdata are valid in cycle N+1..N+2. Request to ack is 2 edges.
- **Throughput:** one access per 2 cycles for a single port. Back-to-back from the same port, ack and the next SERVE do not overlap.
- **Reset mid-operation:** an asserted `rst_n` forces IDLE and `mem_we` low immediately (asynchronously), with no ack. A write whose edge has not occurred is lost.
- **Simultaneous events:** a request from the other port arriving during SERVE_x waits for the ack/IDLE cycle, then wins by round-robin.
- **Boundaries:**
  - `addr = DEPTH-1` is valid.
  - `addr = DEPTH` and above give `err = 1`, no `mem_we` pulse, and `rdata = 0`.

## Test plan

- **Single read on A:** preload mem[32] = 0x00000010. Hold A read at addr 32. Required: `a_ack` high exactly 2 edges after the request, `a_rdata = 0x00000010`, `a_err = 0`, `mem_we` never high.
- **Write then read on B:** B writes 0xDEADBEEF to addr 1023. Required: `mem_we` high for exactly one cycle with `mem_addr = 1023`, `b_ack` pulses. Then B reads 1023. Required: `b_rdata = 0xDEADBEEF`.
- **Out of range:** A reads addr 1024, then writes 0xFFFFFFFF. Required: both acks have `a_err = 1`, `a_rdata = 0`, `mem_we` stays 0, memory is unchanged.
- **Contention:** A and B request continuously from reset, with A reading addr 0 and B reading addr 1. Required: grant order A, B, A, B, and acks alternate every 2 cycles.
- **Reset during SERVE_B write:** assert `rst_n` low mid-cycle. Required: `mem_we` falls without waiting for a clock, no `b_ack`, all outputs return to their reset values, and the target word is unchanged.
- **Back-to-back:** A keeps `req` high through its ack cycle with a new address, while B is idle. Required: a second SERVE_A follows the ack cycle immediately, and acks occur every 2 cycles.
